// File: rtl/step_clock_ctrl.sv
// step_clock_ctrl: run/single-step clock-enable generator; define STEP_TICK_COUNT_EN to enable the tick_count counter
module step_clock_ctrl #(
  parameter int DIV      = 6_000_000,
  parameter int DEBOUNCE = 500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_mode,
  input  logic        step_key_n,
  output logic        clk_en,
  output logic        mode_run,
  output logic [15:0] tick_count
);
  localparam int DW  = $clog2(DIV);
  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam logic [0:0] STEP = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [1:0]     key_s_q, key_s_d, run_s_q, run_s_d;
  logic           db_key_q, db_key_d, db_prev_q, db_prev_d, press_q, press_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic [0:0]     state_q, state_d;
  logic [DW-1:0]  div_cnt_q, div_cnt_d;
  logic           clk_en_q, clk_en_d;
  logic           db_hit, mode_chg, div_wrap;
  // next-state: synchronizers, debounce, edge detect, mode FSM and divider
  always_comb begin
    key_s_d   = {key_s_q[0], step_key_n};
    run_s_d   = {run_s_q[0], run_mode};
    db_hit    = (key_s_q[1] != db_key_q) && (db_cnt_q == DBW'(DEBOUNCE - 1));
    db_cnt_d  = (key_s_q[1] == db_key_q || db_hit) ? '0 : db_cnt_q + 1'b1;
    db_key_d  = db_hit ? key_s_q[1] : db_key_q;
    db_prev_d = db_key_q;
    press_d   = db_prev_q & ~db_key_q;
    mode_chg  = state_q != run_s_q[1];
    state_d   = run_s_q[1];
    div_wrap  = div_cnt_q == DW'(DIV - 1);
    div_cnt_d = (mode_chg || state_q == STEP || div_wrap) ? '0 : div_cnt_q + 1'b1;
    clk_en_d  = mode_chg ? 1'b0 : (state_q == RUN) ? div_wrap : press_q;
  end
  // state registers; the key path idles high so reset never fakes a press
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_s_q   <= 2'b11;
      run_s_q   <= 2'b00;
      db_key_q  <= 1'b1;
      db_prev_q <= 1'b1;
      press_q   <= 1'b0;
      db_cnt_q  <= '0;
      state_q   <= STEP;
      div_cnt_q <= '0;
      clk_en_q  <= 1'b0;
    end else begin
      key_s_q   <= key_s_d;
      run_s_q   <= run_s_d;
      db_key_q  <= db_key_d;
      db_prev_q <= db_prev_d;
      press_q   <= press_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      clk_en_q  <= clk_en_d;
    end
  end
  assign clk_en   = clk_en_q;
  assign mode_run = state_q == RUN;
`ifdef STEP_TICK_COUNT_EN
  logic [15:0] tick_q, tick_d;
  // count issued pulses, wrapping naturally at 16 bits
  always_comb tick_d = tick_q + 16'(clk_en_q);
  // tick counter register
  always_ff @(posedge clk) begin
    if (!reset) tick_q <= '0;
    else tick_q <= tick_d;
  end
  assign tick_count = tick_q;
`else
  assign tick_count = 16'h0000;
`endif
endmodule
